// File: rtl/dummy_stim_pkg.sv
// Shared FSM state type, LFSR definition and latency limits for dummy_stim_ctrl.
package dummy_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stim_state_e;

  localparam int LFSR_W = 8;
  // Taps 8,6,5,4 (1-based) land on bits 7,5,4,3; feedback enters bit 7.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/dummy_stim_lfsr.sv
// Seedable, enable-gated 8-bit Fibonacci LFSR. A load presents SEED[0] in the
// same cycle and steps past it, so the first stream bit costs no extra cycle.
module dummy_stim_lfsr
  import dummy_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_en,
  output logic o_bit
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_cur;

  assign w_cur = i_load ? SEED : r_state;
  assign o_bit = w_cur[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SEED;
    end else if (i_load || i_en) begin
      r_state <= lfsr_next(w_cur);
    end
  end

endmodule

// File: rtl/dummy_stim_ctrl.sv
// LFSR stimulus driver and dual-output checker for the registered dummy cell.
// Define DUMMY_STIM_XCHK_EN for 4-state compare and x_seen tracking (sim only).
//
// state    | meaning
// ST_IDLE  | waiting for start, results held
// ST_RUN   | driving stream bits on d
// ST_DRAIN | d=0, waiting LAT cycles for last compares
// ST_DONE  | one-cycle done pulse
module dummy_stim_ctrl
  import dummy_stim_pkg::*;
#(
  parameter int                CNT_W = 8,
  parameter logic [LFSR_W-1:0] SEED  = 8'hA5,
  parameter int                LAT   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bits,
  output logic             d,
  input  logic             q_a,
  input  logic             q_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             err_valid,
  output logic             x_seen
);

  localparam int                DRAIN_W    = $clog2(LAT_MAX);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(LAT - LAT_MIN);

  stim_state_e         r_state;
  logic [CNT_W-1:0]    r_remain;
  logic [DRAIN_W-1:0]  r_drain;
  logic                r_d;
  logic                r_d_vld;
  logic                r_busy;
  logic                r_done;
  logic [LAT-1:0]      r_exp;
  logic [LAT-1:0]      r_vld;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_first_idx;
  logic [CNT_W-1:0]    r_cmp_idx;
  logic                r_err_valid;

  logic                w_accept;
  logic                w_step;
  logic                w_bit;
  logic                w_cmp;
  logic                w_mis;
  logic [LAT:0]        w_exp_sh;
  logic [LAT:0]        w_vld_sh;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_step   = (r_state == ST_RUN) && (r_remain != '0);

  dummy_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_accept),
    .i_en   (w_step),
    .o_bit  (w_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_drain  <= '0;
      r_d      <= 1'b0;
      r_d_vld  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_d     <= 1'b0;
      r_d_vld <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (num_bits == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_remain <= num_bits - 1'b1;
              r_d      <= w_bit;
              r_d_vld  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_remain == '0) begin
            r_state <= ST_DRAIN;
            r_drain <= DRAIN_INIT;
          end else begin
            r_remain <= r_remain - 1'b1;
            r_d      <= w_bit;
            r_d_vld  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The delay line is fed from the registered d, so its tail lines up with q.
  assign w_exp_sh = {r_exp, r_d};
  assign w_vld_sh = {r_vld, r_d_vld};
  assign w_cmp    = r_vld[LAT-1];

`ifdef DUMMY_STIM_XCHK_EN
  logic r_x_seen;
  assign w_mis = (q_a !== r_exp[LAT-1]) || (q_b !== r_exp[LAT-1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x_seen <= 1'b0;
    end else if (w_accept) begin
      r_x_seen <= 1'b0;
    end else if (w_cmp && $isunknown({q_a, q_b})) begin
      r_x_seen <= 1'b1;
    end
  end
  assign x_seen = r_x_seen;
`else
  assign w_mis  = (q_a != r_exp[LAT-1]) || (q_b != r_exp[LAT-1]);
  assign x_seen = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_exp       <= '0;
      r_vld       <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_cmp_idx   <= '0;
      r_err_valid <= 1'b0;
    end else begin
      r_exp <= w_exp_sh[LAT-1:0];
      r_vld <= w_vld_sh[LAT-1:0];
      if (w_accept) begin
        r_err_cnt   <= '0;
        r_first_idx <= '0;
        r_cmp_idx   <= '0;
        r_err_valid <= 1'b0;
      end else if (w_cmp) begin
        r_cmp_idx <= r_cmp_idx + 1'b1;
        if (w_mis) begin
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
          if (!r_err_valid) begin
            r_err_valid <= 1'b1;
            r_first_idx <= r_cmp_idx;
          end
        end
      end
    end
  end

  assign d             = r_d;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign err_valid     = r_err_valid;

endmodule

// File: tb/tb_dummy_stim_ctrl.sv
// Scoreboard bench for dummy_stim_ctrl: a bench-side registered cell model with
// per-bit fault injection drives q_a/q_b; a negedge monitor checks every run.
module tb_dummy_stim_ctrl;

  localparam int               CNT_W = 8;
  localparam int               LAT   = 1;
  localparam logic [7:0]       SEED  = 8'hA5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_bits = '0;
  logic             d, busy, done, err_valid, x_seen;
  logic [CNT_W-1:0] err_cnt, first_err_idx;
  logic             q_a, q_b;

  logic             r_q = 1'b0;
  int               q_idx = -1;
  logic [255:0]     flip_a = '0, flip_b = '0, x_a = '0;

  typedef struct {
    int           n;
    logic [255:0] bits;
    int           done_cyc;
    int           exp_err;
    int           exp_first;
    bit           exp_valid;
    bit           exp_x;
    bit           abort;
  } run_t;

  run_t exp_q[$];
  run_t cur;
  bit   active = 0;
  bit   prev_busy = 0;
  int   run_cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dummy_stim_ctrl #(.CNT_W(CNT_W), .SEED(SEED), .LAT(LAT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .num_bits      (num_bits),
    .d             (d),
    .q_a           (q_a),
    .q_b           (q_b),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .err_valid     (err_valid),
    .x_seen        (x_seen)
  );

  // Registered cell model (latency LAT=1); q_idx tags which stream bit q carries.
  always @(posedge clk) begin
    r_q   <= d;
    q_idx <= run_cyc - 1;
  end

  always_comb begin
    q_a = r_q;
    q_b = r_q;
    if (q_idx >= 0 && q_idx < 256) begin
      if (flip_a[q_idx]) q_a = ~r_q;
      if (flip_b[q_idx]) q_b = ~r_q;
`ifdef DUMMY_STIM_XCHK_EN
      if (x_a[q_idx]) q_a = 1'bx;
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic run_t model(input int n, input logic [255:0] fa, input logic [255:0] fb,
                                 input logic [255:0] xa);
    run_t       r;
    logic [7:0] s;
    s = SEED;
    r.n = n; r.bits = '0; r.exp_err = 0; r.exp_first = 0;
    r.exp_valid = 0; r.exp_x = 0; r.abort = 0;
    for (int i = 0; i < n; i++) begin
      r.bits[i] = s[0];
      s = {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
      if (fa[i] || fb[i] || xa[i]) begin
        if (!r.exp_valid) begin
          r.exp_valid = 1;
          r.exp_first = i;
        end
        if (r.exp_err < 255) r.exp_err++;
      end
      if (xa[i]) r.exp_x = 1;
    end
    r.done_cyc = (n == 0) ? 1 : 1 + n + LAT;
    return r;
  endfunction

  // Monitor: numbers busy cycles from 1 and checks d, done and the results.
  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) begin
        run_cyc = 1;
        chk("run_queued", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur    = exp_q.pop_front();
          active = 1;
        end
      end else begin
        run_cyc++;
        if (!active) chk("busy_after_done", busy, 0);
      end
      if (active) begin
        chk("d", d, (run_cyc <= cur.n) ? cur.bits[run_cyc-1] : 1'b0);
        chk("done_timing", done, (run_cyc == cur.done_cyc));
        if (run_cyc == cur.done_cyc) begin
          chk("err_cnt", err_cnt, cur.exp_err);
          chk("first_err_idx", first_err_idx, cur.exp_first);
          chk("err_valid", err_valid, cur.exp_valid);
          chk("x_seen", x_seen, cur.exp_x);
          active = 0;
        end
      end
    end else begin
      if (active) begin
        if (cur.abort) chk("abort_before_done", (run_cyc < cur.done_cyc), 1);
        else           chk("busy_until_done", run_cyc, cur.done_cyc);
        active = 0;
      end
      chk("done_idle", done, 0);
      run_cyc = 0;
    end
    prev_busy = busy;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d"}, d, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first_err_idx"}, first_err_idx, 0);
    chk({tag, "_err_valid"}, err_valid, 0);
    chk({tag, "_x_seen"}, x_seen, 0);
  endtask

  task automatic do_run(input int n, input logic [255:0] fa, input logic [255:0] fb,
                        input logic [255:0] xa, input int restart_cyc, input int abort_cyc);
    run_t r;
    bit   fin;
    r       = model(n, fa, fb, xa);
    r.abort = (abort_cyc > 0);
    flip_a  = fa;
    flip_b  = fb;
    x_a     = xa;
    exp_q.push_back(r);
    @(posedge clk); #1;
    start    = 1'b1;
    num_bits = CNT_W'(n);
    @(posedge clk); #1;
    start    = 1'b0;
    num_bits = CNT_W'($urandom);
    fin = 0;
    for (int t = 0; t < n + LAT + 10; t++) begin
      @(negedge clk); #1;
      if (!busy) begin
        fin = 1;
        break;
      end
      if (abort_cyc > 0 && run_cyc == abort_cyc) begin
        rstn = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (3) @(posedge clk);
        fin = 1;
        break;
      end
      if (restart_cyc > 0 && run_cyc == restart_cyc) begin
        start    = 1'b1;
        num_bits = CNT_W'($urandom_range(1, 5));
        @(posedge clk); #1;
        start    = 1'b0;
      end
    end
    chk("run_finished", fin, 1);
  endtask

  initial begin
    logic [255:0] fa, fb, none;
    int           n;
    none = '0;

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    do_run(0, none, none, none, 0, 0);
    do_run(16, none, none, none, 0, 0);

    fb = '0; fb[5] = 1'b1;
    do_run(16, none, fb, none, 0, 0);

    fa = '0; fa[3] = 1'b1; fa[4] = 1'b1; fa[9] = 1'b1;
    do_run(16, fa, fa, none, 0, 0);

    do_run(20, none, none, none, 5, 0);
    do_run(12, none, fb, none, 1 + 12 + LAT, 0);
    do_run(20, none, none, none, 0, 6);
    do_run(0, none, none, none, 0, 0);

    for (int k = 0; k < 8; k++) begin
      n  = $urandom_range(1, 60);
      fa = '0;
      fb = '0;
      for (int i = 0; i < n; i++) begin
        fa[i] = ($urandom_range(0, 7) == 0);
        fb[i] = ($urandom_range(0, 7) == 0);
      end
      do_run(n, fa, fb, none, 0, 0);
    end

    fa = '0;
    fb = '0;
    for (int i = 0; i < 255; i++) begin
      fa[i] = ($urandom_range(0, 15) == 0);
      fb[i] = ($urandom_range(0, 15) == 0);
    end
    do_run(255, fa, fb, none, 0, 0);

`ifdef DUMMY_STIM_XCHK_EN
    fa = '0; fa[2] = 1'b1;
    do_run(8, none, none, fa, 0, 0);
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
